exp3_unidade_controle: RTL and testbench

- Control unit (Moore FSM) that drives the exp3 datapath (exp3_fluxo_dados) across its control/status interface.
- Issues zeraC/zeraR/registraR/contaC and consumes fimC/chavesIgualMemoria.
- Sequences a 16-entry memory check: wait for a keypress, register the switches, compare against memory, advance the address.
- Ends in a hit or miss state and reports the current state on a debug bus.

---
 rtl/exp3_unidade_controle.sv | 144 ++++++++++++++
 tb/tb_exp3_unidade_controle.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exp3_unidade_controle.sv
// Moore control unit sequencing the exp3 16-entry memory check over the datapath.
// Optional ESPERA timeout is built when the TIMEOUT_EN macro is defined.
module exp3_unidade_controle #(
    parameter int unsigned TIMEOUT_CICLOS = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       chavesIgualMemoria,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        Inicial    = 4'b0000,
        Prepara    = 4'b0001,
        Espera     = 4'b0010,
        Registra   = 4'b0100,
        Compara    = 4'b0101,
        Proximo    = 4'b0110,
        FimAcerto  = 4'b1010,
        FimTimeout = 4'b1101,
        FimErro    = 4'b1110
    } estado_t;

    estado_t estadoAtual;
    estado_t proximoEstado;
    logic    jogadaD;
    logic    jogadaPulso;
    logic    timeoutFim;

    assign jogadaPulso = jogada & ~jogadaD;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogadaD <= 1'b0;
        end else begin
            jogadaD <= jogada;
        end
    end

`ifdef TIMEOUT_EN
    localparam int unsigned TimeoutW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TimeoutW-1:0] TimeoutUltimo = TimeoutW'(TIMEOUT_CICLOS - 1);

    logic [TimeoutW-1:0] contTimeout;

    // Held at zero outside ESPERA, so every entry starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contTimeout <= '0;
        end else if (estadoAtual != Espera) begin
            contTimeout <= '0;
        end else begin
            contTimeout <= contTimeout + 1'b1;
        end
    end

    assign timeoutFim = (contTimeout == TimeoutUltimo);
`else
    assign timeoutFim = 1'b0;
`endif

    always_comb begin
        proximoEstado = estadoAtual;
        case (estadoAtual)
            Inicial:    proximoEstado = iniciar ? Prepara : Inicial;
            Prepara:    proximoEstado = Espera;
            Espera: begin
                // A keypress on the terminal-count cycle still wins over the timeout.
                if (jogadaPulso) begin
                    proximoEstado = Registra;
                end else if (timeoutFim) begin
                    proximoEstado = FimTimeout;
                end else begin
                    proximoEstado = Espera;
                end
            end
            Registra:   proximoEstado = Compara;
            Compara: begin
                if (!chavesIgualMemoria) begin
                    proximoEstado = FimErro;
                end else if (fimC) begin
                    proximoEstado = FimAcerto;
                end else begin
                    proximoEstado = Proximo;
                end
            end
            Proximo:    proximoEstado = Espera;
            FimAcerto:  proximoEstado = iniciar ? Prepara : FimAcerto;
            FimErro:    proximoEstado = iniciar ? Prepara : FimErro;
            FimTimeout: proximoEstado = iniciar ? Prepara : FimTimeout;
            default:    proximoEstado = Inicial;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoAtual <= Inicial;
            zeraC       <= 1'b0;
            zeraR       <= 1'b0;
            registraR   <= 1'b0;
            contaC      <= 1'b0;
            pronto      <= 1'b0;
            acertou     <= 1'b0;
            errou       <= 1'b0;
        end else begin
            estadoAtual <= proximoEstado;
            zeraC       <= (proximoEstado == Prepara);
            zeraR       <= (proximoEstado == Prepara);
            registraR   <= (proximoEstado == Registra);
            contaC      <= (proximoEstado == Proximo);
            pronto      <= (proximoEstado == FimAcerto) || (proximoEstado == FimErro) ||
                           (proximoEstado == FimTimeout);
            acertou     <= (proximoEstado == FimAcerto);
            errou       <= (proximoEstado == FimErro) || (proximoEstado == FimTimeout);
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_timeout <= 1'b0;
        end else begin
            db_timeout <= (proximoEstado == FimTimeout);
        end
    end
`else
    assign db_timeout = 1'b0;
`endif

    assign db_estado = estadoAtual;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Directed bench for exp3_unidade_controle: reset, start, miss, full hit, ignored inputs,
// and (with TIMEOUT_EN) the ESPERA timeout.
module tb_exp3_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       fimC;
    logic       chavesIgualMemoria;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       db_timeout;
    logic [3:0] db_estado;

    int nTestes = 0;
    int nFalhas = 0;
    int nReg    = 0;
    int nConta  = 0;

    exp3_unidade_controle #(
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .fimC               (fimC),
        .chavesIgualMemoria (chavesIgualMemoria),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .db_timeout         (db_timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    task automatic checa(input string tag, input int obs, input int esp);
        nTestes++;
        if (obs != esp) begin
            nFalhas++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Checks the state bus plus every control/status output in one go.
    task automatic checaSaidas(input string tag, input int db, input int zc, input int cc,
                               input int zr, input int rr, input int pr, input int ac,
                               input int er);
        checa({tag, ".db_estado"}, int'(db_estado), db);
        checa({tag, ".zeraC"}, int'(zeraC), zc);
        checa({tag, ".contaC"}, int'(contaC), cc);
        checa({tag, ".zeraR"}, int'(zeraR), zr);
        checa({tag, ".registraR"}, int'(registraR), rr);
        checa({tag, ".pronto"}, int'(pronto), pr);
        checa({tag, ".acertou"}, int'(acertou), ac);
        checa({tag, ".errou"}, int'(errou), er);
    endtask

    task automatic passo;
        @(posedge clock);
        #1;
        if (registraR) nReg++;
        if (contaC) nConta++;
    endtask

    initial begin
        reset = 1'b0;
        iniciar = 1'b0;
        jogada = 1'b0;
        fimC = 1'b0;
        chavesIgualMemoria = 1'b1;
        passo;
        passo;
        checaSaidas("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        checa("reset.db_timeout", int'(db_timeout), 0);
        reset = 1'b1;
        passo;
        checa("idle", int'(db_estado), 0);

        // Start, then a key held for five cycles
        iniciar = 1'b1;
        passo;
        checaSaidas("prepara", 1, 1, 0, 1, 0, 0, 0, 0);
        iniciar = 1'b0;
        passo;
        checaSaidas("espera", 2, 0, 0, 0, 0, 0, 0, 0);
        nReg = 0;
        nConta = 0;
        jogada = 1'b1;
        passo;
        checaSaidas("registra", 4, 0, 0, 0, 1, 0, 0, 0);
        passo;
        checaSaidas("compara", 5, 0, 0, 0, 0, 0, 0, 0);
        passo;
        passo;
        passo;
        checa("held.estado", int'(db_estado), 2);
        checa("held.nReg", nReg, 1);
        checa("held.nConta", nConta, 1);
        jogada = 1'b0;
        passo;

        // Miss with fimC also high: mismatch wins
        jogada = 1'b1;
        passo;
        jogada = 1'b0;
        chavesIgualMemoria = 1'b0;
        fimC = 1'b1;
        nConta = 0;
        passo;
        passo;
        checaSaidas("fimErro", 14, 0, 0, 0, 0, 1, 0, 1);
        passo;
        checa("fimErro.stay", int'(db_estado), 14);
        checa("fimErro.nConta", nConta, 0);
        iniciar = 1'b1;
        chavesIgualMemoria = 1'b1;
        fimC = 1'b0;
        passo;
        checa("restart.estado", int'(db_estado), 1);
        iniciar = 1'b0;
        passo;

        // Full hit over 16 entries, with ignored inputs injected on entry 3
        nReg = 0;
        nConta = 0;
        for (int i = 0; i < 16; i++) begin
            chavesIgualMemoria = 1'b1;
            fimC = (i == 15);
            jogada = 1'b1;
            passo;
            jogada = 1'b0;
            if (i == 3) begin
                passo;
                jogada = 1'b1;
                iniciar = 1'b1;
                passo;
                checa("ignored.proximo", int'(db_estado), 6);
                iniciar = 1'b0;
                passo;
                passo;
                checa("heldReentry.estado", int'(db_estado), 2);
                jogada = 1'b0;
                iniciar = 1'b1;
                passo;
                checa("iniciarEspera.estado", int'(db_estado), 2);
                iniciar = 1'b0;
            end else begin
                passo;
                passo;
                if (i < 15) passo;
            end
        end
        checaSaidas("fimAcerto", 10, 0, 0, 0, 0, 1, 1, 0);
        checa("hit.nConta", nConta, 15);
        checa("hit.nReg", nReg, 16);
        fimC = 1'b0;

        // Reset asserted asynchronously while in PROXIMO
        iniciar = 1'b1;
        passo;
        iniciar = 1'b0;
        passo;
        jogada = 1'b1;
        passo;
        jogada = 1'b0;
        passo;
        passo;
        checaSaidas("proximo", 6, 0, 1, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checaSaidas("asyncReset", 0, 0, 0, 0, 0, 0, 0, 0);
        passo;
        reset = 1'b1;
        passo;
        checa("postReset.estado", int'(db_estado), 0);
        passo;
        checa("postReset.stay", int'(db_estado), 0);

`ifdef TIMEOUT_EN
        iniciar = 1'b1;
        passo;
        iniciar = 1'b0;
        passo;
        for (int i = 0; i < 7; i++) passo;
        checa("toPre.estado", int'(db_estado), 2);
        passo;
        checaSaidas("fimTimeout", 13, 0, 0, 0, 0, 1, 0, 1);
        checa("fimTimeout.db_timeout", int'(db_timeout), 1);
        iniciar = 1'b1;
        passo;
        iniciar = 1'b0;
        passo;
        for (int i = 0; i < 7; i++) passo;
        jogada = 1'b1;
        passo;
        checa("toJogada.estado", int'(db_estado), 4);
        checa("toJogada.db_timeout", int'(db_timeout), 0);
        jogada = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", nTestes, nFalhas);
        $finish;
    end

endmodule
